o_delay_tap_ctrl: RTL and testbench

Sequencing controller for a single O_DELAY output-delay primitive. It accepts tap commands over a valid/ready request port and drives the primitive's DLY_LOAD, DLY_ADJ and DLY_INCDEC strobes, one step at a time. After each step it waits for the tap to settle and checks the read-back DLY_TAP_VALUE. It sits between fabric control logic or a CSR block and the O_DELAY, so no other logic touches the delay strobes directly.

---
 rtl/o_delay_tap_ctrl.sv | 153 +++++++++++++++
 tb/tb_o_delay_tap_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/o_delay_tap_ctrl.sv
// o_delay_tap_ctrl: sequences LOAD/ADJ/INCDEC strobes of one O_DELAY primitive
// and verifies the read-back tap value after each settled step.
module o_delay_tap_ctrl #(
    parameter int TAP_W      = 6,
    parameter int MAX_TAP    = 63,
    parameter int SETTLE_CYC = 2,
    parameter int CTRL_INV   = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_cmd_i,
    input  logic [TAP_W-1:0] req_tap_i,
    output logic             done_o,
    output logic             err_o,
    output logic [TAP_W-1:0] tap_o,
    output logic             busy_o,
    output logic             dly_ld_o,
    output logic             dly_adj_o,
    output logic             dly_incdec_o,
    input  logic [TAP_W-1:0] dly_tap_val_i
);
    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic INA = (CTRL_INV != 0);
    localparam logic ACT = !INA;
    localparam logic [TAP_W:0] MAX_X = (TAP_W+1)'(MAX_TAP);
    localparam logic [TAP_W:0] RUN_X = (TAP_W+1)'(MAX_TAP + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC - 1);
    localparam logic [1:0] C_LOAD = 2'd0, C_SET = 2'd1, C_INC = 2'd2;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_ADJ = 3'd2,
                           S_SETTLE = 3'd3, S_CHECK = 3'd4, S_DONE = 3'd5;

    logic [2:0]       r_state;
    logic             r_live;
    logic [1:0]       r_cmd;
    logic [TAP_W-1:0] r_tgt, r_prev, r_tap;
    logic             r_dir, r_done, r_err, r_ld, r_adj, r_incdec;
    logic [TAP_W:0]   r_steps;
    logic [CW-1:0]    r_cnt;

    logic             w_acc, w_up;
    logic [TAP_W:0]   w_tap_x;
    logic [TAP_W-1:0] w_step;

    assign req_ready_o  = r_live && (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign tap_o        = r_tap;
    assign dly_ld_o     = r_ld;
    assign dly_adj_o    = r_adj;
    assign dly_incdec_o = r_incdec;

    assign w_acc   = req_valid_i && req_ready_o;
    assign w_tap_x = {1'b0, dly_tap_val_i};
    assign w_up    = r_tgt > dly_tap_val_i;
    // r_prev holds the tap seen before the last step, so this is where that step should have landed
    assign w_step  = r_dir ? r_prev + TAP_W'(1) : r_prev - TAP_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_live   <= 1'b0;
            r_cmd    <= C_LOAD;
            r_tgt    <= '0;
            r_prev   <= '0;
            r_tap    <= '0;
            r_dir    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ld     <= INA;
            r_adj    <= INA;
            r_incdec <= INA;
            r_steps  <= '0;
            r_cnt    <= '0;
        end else begin
            r_live   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ld     <= INA;
            r_adj    <= INA;
            r_incdec <= INA;
            case (r_state)
                S_IDLE: if (w_acc) begin
                    r_cmd   <= req_cmd_i;
                    r_tgt   <= req_tap_i;
                    r_prev  <= dly_tap_val_i;
                    r_steps <= '0;
                    r_dir   <= (req_cmd_i == C_INC);
                    if (req_cmd_i == C_LOAD) begin
                        r_state <= S_LOAD;
                        r_ld    <= ACT;
                    end else if (req_cmd_i == C_SET) begin
                        r_state <= ({1'b0, req_tap_i} > MAX_X) ? S_DONE : S_CHECK;
                        r_done  <= ({1'b0, req_tap_i} > MAX_X);
                        r_err   <= ({1'b0, req_tap_i} > MAX_X);
                    end else if ((req_cmd_i == C_INC) ? (w_tap_x == MAX_X) : (w_tap_x == '0)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_state  <= S_ADJ;
                        r_adj    <= ACT;
                        r_incdec <= (req_cmd_i == C_INC) ? ACT : INA;
                    end
                end
                S_LOAD: begin
                    r_state <= S_SETTLE;
                    r_cnt   <= CNT_INIT;
                end
                S_ADJ: begin
                    r_state  <= S_SETTLE;
                    r_cnt    <= CNT_INIT;
                    r_steps  <= r_steps + 1'b1;
                    r_incdec <= r_incdec;
                end
                S_SETTLE: if (r_cnt != '0) begin
                    r_cnt    <= r_cnt - 1'b1;
                    r_incdec <= r_incdec;
                end else if (r_cmd == C_LOAD) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_tap   <= dly_tap_val_i;
                end else begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_tap <= dly_tap_val_i;
                    if (r_cmd[1]) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= (dly_tap_val_i != w_step);
                    end else if (dly_tap_val_i == r_tgt) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if ((r_steps == RUN_X) || ((r_steps != '0) && (dly_tap_val_i != w_step))) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_state  <= S_ADJ;
                        r_adj    <= ACT;
                        r_dir    <= w_up;
                        r_incdec <= w_up ? ACT : INA;
                        r_prev   <= dly_tap_val_i;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_o_delay_tap_ctrl.sv
// tb_o_delay_tap_ctrl: directed and random commands against an O_DELAY tap model,
// checking latency, strobe pulses, err and tap results from command-level arithmetic.
module tb_o_delay_tap_ctrl;
    localparam int TW = 7;
    localparam int MAXT = 63;
    localparam int S = 2;

    logic          clk = 1'b0, rst = 1'b1, valid = 1'b0;
    logic [1:0]    cmd = 2'd0;
    logic [TW-1:0] tgt = '0, m_tap = '0, m_preset = '0;
    logic          m_force = 1'b0, stuck = 1'b0;
    logic          d_rdy, d_done, d_err, d_busy, d_ld, d_adj, d_id;
    logic          i_rdy, i_done, i_err, i_busy, i_ld, i_adj, i_id;
    logic [TW-1:0] d_tap, i_tap;
    int            ntest = 0, nfail = 0, exp_tap_o = 0;

    always #5 clk = ~clk;

    o_delay_tap_ctrl #(.TAP_W(TW), .MAX_TAP(MAXT), .SETTLE_CYC(S), .CTRL_INV(0)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(d_rdy),
        .req_cmd_i(cmd), .req_tap_i(tgt), .done_o(d_done), .err_o(d_err),
        .tap_o(d_tap), .busy_o(d_busy), .dly_ld_o(d_ld), .dly_adj_o(d_adj),
        .dly_incdec_o(d_id), .dly_tap_val_i(m_tap));

    o_delay_tap_ctrl #(.TAP_W(TW), .MAX_TAP(MAXT), .SETTLE_CYC(S), .CTRL_INV(1)) dui (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(i_rdy),
        .req_cmd_i(cmd), .req_tap_i(tgt), .done_o(i_done), .err_o(i_err),
        .tap_o(i_tap), .busy_o(i_busy), .dly_ld_o(i_ld), .dly_adj_o(i_adj),
        .dly_incdec_o(i_id), .dly_tap_val_i(m_tap));

    // O_DELAY primitive model: load, or step by one unless stuck
    always @(posedge clk) begin
        if (m_force || d_ld) m_tap <= m_preset;
        else if (d_adj && !stuck) m_tap <= d_id ? m_tap + 1'b1 : m_tap - 1'b1;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        ntest++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic run(input logic [1:0] c, input int t);
        int start, e_lat, e_err, e_tap, e_adj, e_ld, e_first, e_last, e_dir;
        int lat, adj_n, ld_n, iadj_n, ild_n, first, last;
        start = int'(m_tap);
        e_tap = exp_tap_o; e_err = 0; e_adj = 0; e_ld = 0; e_first = 0; e_dir = 0; e_lat = 1;
        case (c)
            2'd0: begin e_lat = 2 + S; e_tap = int'(m_preset); e_ld = 1; end
            2'd2, 2'd3: begin
                e_dir = (c == 2'd2) ? 1 : 0;
                if (start == ((c == 2'd2) ? MAXT : 0)) e_err = 1;
                else begin
                    e_lat = 3 + S; e_adj = 1; e_first = 1; e_err = int'(stuck);
                    e_tap = stuck ? start : (e_dir != 0 ? start + 1 : start - 1);
                end
            end
            default: begin
                if (t > MAXT) e_err = 1;
                else if (t == start) begin e_lat = 2; e_tap = start; end
                else begin
                    e_dir = (t > start) ? 1 : 0; e_first = 2; e_err = int'(stuck);
                    e_adj = stuck ? 1 : (t > start ? t - start : start - t);
                    e_tap = stuck ? start : t;
                    e_lat = 2 + e_adj * (S + 2);
                end
            end
        endcase
        e_last = (e_adj > 0) ? e_first + (e_adj - 1) * (S + 2) : 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (d_rdy) break;
        end
        chk("ready_before_cmd", int'(d_rdy), 1);
        valid = 1'b1; cmd = c; tgt = TW'(t);
        @(posedge clk);
        #1 valid = 1'b0;
        lat = -1; adj_n = 0; ld_n = 0; iadj_n = 0; ild_n = 0; first = 0; last = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (d_adj) begin
                adj_n++; last = k;
                if (first == 0) first = k;
                chk("incdec_dir", int'(d_id), e_dir);
                chk("inv_incdec_dir", int'(i_id), 1 - e_dir);
            end
            if (d_ld) ld_n++;
            if (!i_adj) iadj_n++;
            if (!i_ld) ild_n++;
            if (d_ld && d_adj) chk("ld_adj_overlap", 1, 0);
            if (d_done) begin lat = k; break; end
        end
        chk("latency", lat, e_lat);
        chk("err", int'(d_err), e_err);
        chk("tap_o", int'(d_tap), e_tap);
        chk("adj_pulses", adj_n, e_adj);
        chk("first_adj", first, e_first);
        chk("last_adj", last, e_last);
        chk("ld_pulses", ld_n, e_ld);
        chk("inv_adj_pulses", iadj_n, e_adj);
        chk("inv_ld_pulses", ild_n, e_ld);
        exp_tap_o = e_tap;
        @(negedge clk);
        chk("done_one_cycle", int'(d_done), 0);
        chk("ready_after_done", int'(d_rdy), 1);
    endtask

    initial begin
        m_preset = TW'(10); m_force = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(d_rdy), 0);
        chk("rst_done", int'(d_done), 0);
        chk("rst_busy", int'(d_busy), 0);
        chk("rst_tap", int'(d_tap), 0);
        chk("rst_strobes", int'({d_ld, d_adj, d_id}), 0);
        chk("rst_inv_strobes", int'({i_ld, i_adj, i_id}), 7);
        m_force = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(d_rdy), 1);
        run(2'd2, 0);
        m_preset = TW'(7);  run(2'd0, 0);
        m_preset = TW'(10); run(2'd0, 0);
        run(2'd1, 13);
        m_preset = TW'(0);  run(2'd0, 0);
        run(2'd3, 0);
        run(2'd1, 64);
        m_preset = TW'(63); run(2'd0, 0);
        run(2'd2, 0);
        m_preset = TW'(20); run(2'd0, 0);
        stuck = 1'b1; run(2'd1, 25); stuck = 1'b0;
        for (int i = 0; i < 25; i++) begin
            logic [1:0] rc;
            rc = 2'($urandom_range(0, 3));
            m_preset = TW'($urandom_range(0, MAXT));
            stuck = ($urandom_range(0, 5) == 0);
            run(rc, (rc == 2'd1) ? int'($urandom_range(0, 70)) : 0);
        end
        stuck = 1'b0;
        m_preset = TW'(10); run(2'd0, 0);
        @(negedge clk);
        valid = 1'b1; cmd = 2'd1; tgt = TW'(30);
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("settle_incdec_held", int'(d_id), 1);
        rst = 1'b1;
        #1;
        chk("midrst_strobes", int'({d_ld, d_adj, d_id}), 0);
        chk("midrst_inv_strobes", int'({i_ld, i_adj, i_id}), 7);
        chk("midrst_ready", int'(d_rdy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", int'(d_done), 0);
        end
        rst = 1'b0;
        exp_tap_o = 0;
        @(negedge clk);
        chk("midrst_ready_after", int'(d_rdy), 1);
        chk("midrst_tap_cleared", int'(d_tap), 0);
        run(2'd2, 0);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
